// File: rtl/int_arith_unit.sv
// Integer execute-stage arithmetic: 64-bit base ALU and RV64M multiply/divide,
// both evaluated combinationally from the same operands every cycle.
module int_arith_unit #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] ia,
    input  logic [XLEN-1:0] ib,
    input  logic [3:0]      aluOp,
    input  logic [3:0]      mulOp,
    output logic [XLEN-1:0] aluOut,
    output logic [XLEN-1:0] mulOut
);

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_XOR   = 4'd4;
    localparam logic [3:0] ALU_SLL   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_SLT   = 4'd8;
    localparam logic [3:0] ALU_SLTU  = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;
    localparam logic [3:0] ALU_SLLW  = 4'd11;
    localparam logic [3:0] ALU_SRLW  = 4'd12;
    localparam logic [3:0] ALU_SRAW  = 4'd13;

    localparam logic [3:0] MUL_MUL    = 4'd0;
    localparam logic [3:0] MUL_MULH   = 4'd1;
    localparam logic [3:0] MUL_MULHSU = 4'd2;
    localparam logic [3:0] MUL_MULHU  = 4'd3;
    localparam logic [3:0] MUL_DIV    = 4'd4;
    localparam logic [3:0] MUL_DIVU   = 4'd5;
    localparam logic [3:0] MUL_REM    = 4'd6;
    localparam logic [3:0] MUL_REMU   = 4'd7;
    localparam logic [3:0] MUL_MULW   = 4'd8;
    localparam logic [3:0] MUL_DIVW   = 4'd9;
    localparam logic [3:0] MUL_DIVUW  = 4'd10;
    localparam logic [3:0] MUL_REMW   = 4'd11;
    localparam logic [3:0] MUL_REMUW  = 4'd12;

    localparam logic [63:0] ALL_ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // clk/rst exist only for interface uniformity; nothing here is stateful.
    logic w_unused_clk_rst;
    assign w_unused_clk_rst = clk ^ rst;

    logic [5:0]  w_shamt;
    logic [4:0]  w_shamt_w;
    logic [63:0] w_sra;
    logic [31:0] w_sraw;
    logic [31:0] w_sllw;
    logic [31:0] w_srlw;
    logic        w_slt;
    logic        w_sltu;

    assign w_shamt   = ib[5:0];
    assign w_shamt_w = ib[4:0];
    assign w_sra     = $unsigned($signed(ia) >>> w_shamt);
    assign w_sraw    = $unsigned($signed(ia[31:0]) >>> w_shamt_w);
    assign w_sllw    = ia[31:0] << w_shamt_w;
    assign w_srlw    = ia[31:0] >> w_shamt_w;
    assign w_slt     = $signed(ia) < $signed(ib);
    assign w_sltu    = ia < ib;

    // ALU result select
    always_comb begin
        aluOut = 64'd0;
        case (aluOp)
            ALU_ADD:   aluOut = ia + ib;
            ALU_SUB:   aluOut = ia - ib;
            ALU_AND:   aluOut = ia & ib;
            ALU_OR:    aluOut = ia | ib;
            ALU_XOR:   aluOut = ia ^ ib;
            ALU_SLL:   aluOut = ia << w_shamt;
            ALU_SRL:   aluOut = ia >> w_shamt;
            ALU_SRA:   aluOut = w_sra;
            ALU_SLT:   aluOut = {63'd0, w_slt};
            ALU_SLTU:  aluOut = {63'd0, w_sltu};
            ALU_PASSB: aluOut = ib;
            ALU_SLLW:  aluOut = sext32(w_sllw);
            ALU_SRLW:  aluOut = sext32(w_srlw);
            ALU_SRAW:  aluOut = sext32(w_sraw);
            default:   aluOut = 64'd0;
        endcase
    end

    // One unsigned 64x64 multiplier; signed high halves are recovered by
    // subtracting the other operand wherever an operand's sign bit is set.
    logic [127:0] w_prod;
    logic [63:0]  w_mulhu;
    logic [63:0]  w_mulhsu;
    logic [63:0]  w_mulh;

    assign w_prod   = {64'd0, ia} * {64'd0, ib};
    assign w_mulhu  = w_prod[127:64];
    assign w_mulhsu = w_mulhu - (ia[63] ? ib : 64'd0);
    assign w_mulh   = w_mulhsu - (ib[63] ? ia : 64'd0);

    // Single unsigned divider on magnitudes; operands are pre-widened for W forms.
    logic        w_div_w;
    logic        w_div_signed;
    logic [63:0] w_dvd;
    logic [63:0] w_dvs;
    logic        w_dvd_neg;
    logic        w_dvs_neg;
    logic [63:0] w_dvd_mag;
    logic [63:0] w_dvs_mag;
    logic        w_dvs_zero;
    logic [63:0] w_dvs_safe;
    logic [63:0] w_q_mag;
    logic [63:0] w_r_mag;
    logic [63:0] w_quot;
    logic [63:0] w_rem;

    assign w_div_w      = (mulOp == MUL_DIVW) || (mulOp == MUL_DIVUW) ||
                          (mulOp == MUL_REMW) || (mulOp == MUL_REMUW);
    assign w_div_signed = (mulOp == MUL_DIV)  || (mulOp == MUL_REM) ||
                          (mulOp == MUL_DIVW) || (mulOp == MUL_REMW);
    assign w_dvd = w_div_w ? (w_div_signed ? sext32(ia[31:0]) : {32'd0, ia[31:0]}) : ia;
    assign w_dvs = w_div_w ? (w_div_signed ? sext32(ib[31:0]) : {32'd0, ib[31:0]}) : ib;

    assign w_dvd_neg  = w_div_signed & w_dvd[63];
    assign w_dvs_neg  = w_div_signed & w_dvs[63];
    assign w_dvd_mag  = w_dvd_neg ? (64'd0 - w_dvd) : w_dvd;
    assign w_dvs_mag  = w_dvs_neg ? (64'd0 - w_dvs) : w_dvs;
    assign w_dvs_zero = (w_dvs == 64'd0);
    assign w_dvs_safe = w_dvs_zero ? 64'd1 : w_dvs_mag;
    assign w_q_mag    = w_dvd_mag / w_dvs_safe;
    assign w_r_mag    = w_dvd_mag % w_dvs_safe;

    // Overflow (MIN / -1) needs no special case: the 2^63 magnitude negates to itself.
    assign w_quot = w_dvs_zero ? ALL_ONES :
                    ((w_dvd_neg ^ w_dvs_neg) ? (64'd0 - w_q_mag) : w_q_mag);
    assign w_rem  = w_dvs_zero ? w_dvd :
                    (w_dvd_neg ? (64'd0 - w_r_mag) : w_r_mag);

    // Multiply/divide result select
    always_comb begin
        mulOut = 64'd0;
        case (mulOp)
            MUL_MUL:    mulOut = w_prod[63:0];
            MUL_MULH:   mulOut = w_mulh;
            MUL_MULHSU: mulOut = w_mulhsu;
            MUL_MULHU:  mulOut = w_mulhu;
            MUL_DIV:    mulOut = w_quot;
            MUL_DIVU:   mulOut = w_quot;
            MUL_REM:    mulOut = w_rem;
            MUL_REMU:   mulOut = w_rem;
            MUL_MULW:   mulOut = sext32(w_prod[31:0]);
            MUL_DIVW:   mulOut = sext32(w_quot[31:0]);
            MUL_DIVUW:  mulOut = sext32(w_quot[31:0]);
            MUL_REMW:   mulOut = sext32(w_rem[31:0]);
            MUL_REMUW:  mulOut = sext32(w_rem[31:0]);
            default:    mulOut = 64'd0;
        endcase
    end

endmodule

// File: tb/tb_int_arith_unit.sv
// Bench for int_arith_unit: directed vector table, reset-transparency sequence,
// and random operands checked against an arithmetic reference model.
module tb_int_arith_unit;

    logic        clk;
    logic        rst;
    logic [63:0] ia;
    logic [63:0] ib;
    logic [3:0]  aluOp;
    logic [3:0]  mulOp;
    logic [63:0] aluOut;
    logic [63:0] mulOut;

    int n_checks;
    int n_pass;

    localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

    int_arith_unit #(.XLEN(64)) dut (
        .clk(clk), .rst(rst), .ia(ia), .ib(ib),
        .aluOp(aluOp), .mulOp(mulOp), .aluOut(aluOut), .mulOut(mulOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          is_mul;
        logic [3:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input string name, input bit is_mul, input logic [3:0] op,
                           input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp);
        vec_t v;
        v.name = name; v.is_mul = is_mul; v.op = op; v.a = a; v.b = b; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [63:0] sx(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    function automatic logic [63:0] ref_alu(input logic [3:0] op, input logic [63:0] a,
                                            input logic [63:0] b);
        longint      sa;
        longint      sb;
        int          si;
        logic [31:0] t;
        sa = a; sb = b; si = a[31:0];
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return a << b[5:0];
            4'd6:  return a >> b[5:0];
            4'd7:  return sa >>> b[5:0];
            4'd8:  return (sa < sb) ? 64'd1 : 64'd0;
            4'd9:  return (a < b) ? 64'd1 : 64'd0;
            4'd10: return b;
            4'd11: begin t = a[31:0] << b[4:0]; return sx(t); end
            4'd12: begin t = a[31:0] >> b[4:0]; return sx(t); end
            4'd13: begin si = si >>> b[4:0]; t = si; return sx(t); end
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic [63:0] ref_mul(input logic [3:0] op, input logic [63:0] a,
                                            input logic [63:0] b);
        logic signed [127:0] p;
        logic [127:0]        pu;
        longint              sa;
        longint              sb;
        int                  x;
        int                  y;
        logic [31:0]         ua;
        logic [31:0]         ub;
        logic [31:0]         t;
        sa = a; sb = b; x = a[31:0]; y = b[31:0]; ua = a[31:0]; ub = b[31:0];
        case (op)
            4'd0: return a * b;
            4'd1: begin p = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b}); return p[127:64]; end
            4'd2: begin p = $signed({{64{a[63]}}, a}) * $signed({64'd0, b}); return p[127:64]; end
            4'd3: begin pu = {64'd0, a} * {64'd0, b}; return pu[127:64]; end
            4'd4: begin
                if (b == 64'd0) return ALL1;
                if (a == MIN64 && b == ALL1) return a;
                return sa / sb;
            end
            4'd5: return (b == 64'd0) ? ALL1 : a / b;
            4'd6: begin
                if (b == 64'd0) return a;
                if (a == MIN64 && b == ALL1) return 64'd0;
                return sa % sb;
            end
            4'd7: return (b == 64'd0) ? a : a % b;
            4'd8: begin t = ua * ub; return sx(t); end
            4'd9: begin
                if (y == 0) return ALL1;
                if (x == 32'sh8000_0000 && y == -1) return sx(ua);
                t = x / y; return sx(t);
            end
            4'd10: begin
                if (ub == 32'd0) return ALL1;
                t = ua / ub; return sx(t);
            end
            4'd11: begin
                if (y == 0) return sx(ua);
                if (x == 32'sh8000_0000 && y == -1) return 64'd0;
                t = x % y; return sx(t);
            end
            4'd12: begin
                if (ub == 32'd0) return sx(ua);
                t = ua % ub; return sx(t);
            end
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic [63:0] rnd_operand();
        logic [63:0] specials [8];
        specials = '{64'd0, 64'd1, ALL1, MIN64, 64'h7FFF_FFFF_FFFF_FFFF,
                     64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0000_FFFF_FFFF};
        if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 7)];
        return {$urandom, $urandom};
    endfunction

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1; ia = 64'd0; ib = 64'd0; aluOp = 4'd0; mulOp = 4'd0;

        add_vec("ADD wrap",      1'b0, 4'd0,  ALL1, 64'd1, 64'd0);
        add_vec("SUB wrap",      1'b0, 4'd1,  64'd0, 64'd1, ALL1);
        add_vec("SLT -1<1",      1'b0, 4'd8,  ALL1, 64'd1, 64'd1);
        add_vec("SLTU -1<1",     1'b0, 4'd9,  ALL1, 64'd1, 64'd0);
        add_vec("SRA 63",        1'b0, 4'd7,  MIN64, 64'd63, ALL1);
        add_vec("SRL 63",        1'b0, 4'd6,  MIN64, 64'd63, 64'd1);
        add_vec("SLL mask",      1'b0, 4'd5,  64'd3, 64'h41, 64'd6);
        add_vec("SRAW",          1'b0, 4'd13, 64'h0000_0000_8000_0000, 64'd4, 64'hFFFF_FFFF_F800_0000);
        add_vec("SLLW sext",     1'b0, 4'd11, 64'd1, 64'd31, 64'hFFFF_FFFF_8000_0000);
        add_vec("SRLW",          1'b0, 4'd12, 64'hFFFF_FFFF_8000_0000, 64'd4, 64'h0000_0000_0800_0000);
        add_vec("PASSB",         1'b0, 4'd10, 64'd5, 64'h1234_5000, 64'h1234_5000);
        add_vec("ALU rsv14",     1'b0, 4'd14, ALL1, ALL1, 64'd0);
        add_vec("ALU rsv15",     1'b0, 4'd15, ALL1, 64'd7, 64'd0);
        add_vec("MUL -1*-1",     1'b1, 4'd0,  ALL1, ALL1, 64'd1);
        add_vec("MULH -1*-1",    1'b1, 4'd1,  ALL1, ALL1, 64'd0);
        add_vec("MULHU max",     1'b1, 4'd3,  ALL1, ALL1, 64'hFFFF_FFFF_FFFF_FFFE);
        add_vec("MULHSU -1*2",   1'b1, 4'd2,  ALL1, 64'd2, ALL1);
        add_vec("MULW",          1'b1, 4'd8,  64'h10000, 64'h10000, 64'd0);
        add_vec("DIV -7/2",      1'b1, 4'd4,  -64'sd7, 64'd2, -64'sd3);
        add_vec("REM -7%2",      1'b1, 4'd6,  -64'sd7, 64'd2, ALL1);
        add_vec("DIVU 7/2",      1'b1, 4'd5,  64'd7, 64'd2, 64'd3);
        add_vec("REMU 7%2",      1'b1, 4'd7,  64'd7, 64'd2, 64'd1);
        add_vec("DIV by 0",      1'b1, 4'd4,  64'd5, 64'd0, ALL1);
        add_vec("REM by 0",      1'b1, 4'd6,  64'd5, 64'd0, 64'd5);
        add_vec("DIV ovf",       1'b1, 4'd4,  MIN64, ALL1, MIN64);
        add_vec("REM ovf",       1'b1, 4'd6,  MIN64, ALL1, 64'd0);
        add_vec("DIVW ovf",      1'b1, 4'd9,  64'h8000_0000, ALL1, 64'hFFFF_FFFF_8000_0000);
        add_vec("REMW ovf",      1'b1, 4'd11, 64'h8000_0000, ALL1, 64'd0);
        add_vec("DIVUW by 0",    1'b1, 4'd10, 64'd9, 64'h1_0000_0000, ALL1);
        add_vec("REMUW by 0",    1'b1, 4'd12, 64'hFFFF_FFFF_8000_0005, 64'd0, 64'hFFFF_FFFF_8000_0005);
        add_vec("MUL rsv13",     1'b1, 4'd13, ALL1, ALL1, 64'd0);
        add_vec("MUL rsv15",     1'b1, 4'd15, 64'd3, 64'd3, 64'd0);

        // Reset high: outputs must follow inputs without any clock edge.
        @(negedge clk);
        ia = 64'd5; ib = 64'd3; aluOp = 4'd0; mulOp = 4'd0;
        #1;
        check("rst ADD", aluOut, 64'd8);
        check("rst MUL", mulOut, 64'd15);
        ia = 64'd10;
        #1;
        check("rst ADD track", aluOut, 64'd13);
        check("rst MUL track", mulOut, 64'd30);
        ib = 64'd0; mulOp = 4'd4;
        #1;
        check("rst DIV0 track", mulOut, ALL1);
        rst = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            ia = vecs[i].a; ib = vecs[i].b;
            aluOp = vecs[i].is_mul ? 4'd0 : vecs[i].op;
            mulOp = vecs[i].is_mul ? vecs[i].op : 4'd0;
            #1;
            if (vecs[i].is_mul) check(vecs[i].name, mulOut, vecs[i].exp);
            else                check(vecs[i].name, aluOut, vecs[i].exp);
        end

        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            ia = rnd_operand();
            ib = ($urandom_range(0, 7) == 0) ? 64'd0 : rnd_operand();
            aluOp = 4'($urandom_range(0, 15));
            mulOp = 4'($urandom_range(0, 15));
            #1;
            if (aluOut !== ref_alu(aluOp, ia, ib))
                $display("  rand alu op=%0d ia=%h ib=%h", aluOp, ia, ib);
            check("rand alu", aluOut, ref_alu(aluOp, ia, ib));
            if (mulOut !== ref_mul(mulOp, ia, ib))
                $display("  rand mul op=%0d ia=%h ib=%h", mulOp, ia, ib);
            check("rand mul", mulOut, ref_mul(mulOp, ia, ib));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/int_arith_unit.md
Name: int_arith_unit

Overview:
- Integer arithmetic core of the execute stage: a 64-bit base ALU plus an RV64M multiply/divide unit.
- Both operate on the same operands, ia = rs1 and ib = rs2 or imm, and produce both results every cycle.
- The execute stage picks between the two results with its rvm flag.
- For *W instructions the execute stage then sign-extends bit 31 of the chosen result.

Parameters:
- XLEN, 64, datapath width; only 64 is supported.

Ports:
- clk  input  1  system clock. Not used internally; kept for interface uniformity.
- rst  input  1  asynchronous, active-high reset. No internal state, so it has no effect on outputs.
- ia  input  64  operand A (rs1).
- ib  input  64  operand B (rs2 or immediate).
- aluOp  input  4  ALU operation select.
- mulOp  input  4  multiply/divide operation select.
- aluOut  output  64  ALU result.
- mulOut  output  64  multiply/divide result.

Behaviour:
- Purely combinational.
  - Latency 0: outputs settle in the same cycle the inputs change.
  - No handshake, no stall; the execute stage registers the results at the next clk edge.
- Reset: there are no registers, so no output has a reset value. Outputs always equal the function of the current inputs, including while rst is high.
- aluOp encoding:
  - 0 ADD: ia+ib, wraps mod 2^64.
  - 1 SUB: ia-ib, wraps mod 2^64.
  - 2 AND; 3 OR; 4 XOR.
  - 5 SLL: ia<<ib[5:0].
  - 6 SRL: logical right shift by ib[5:0].
  - 7 SRA: arithmetic right shift by ib[5:0].
  - 8 SLT: signed ia<ib gives 1, else 0.
  - 9 SLTU: unsigned ia<ib gives 1, else 0.
  - 10 PASSB: ib (used for LUI).
  - 11 SLLW: ia[31:0]<<ib[4:0].
  - 12 SRLW: ia[31:0] logical right shift by ib[4:0].
  - 13 SRAW: ia[31:0] arithmetic right shift by ib[4:0].
  - 14, 15: reserved, output 0.
- All W results (aluOp 11–13, mulOp 8–12) are sign-extended from bit 31 to 64 bits.
- mulOp encoding:
  - 0 MUL: low 64 bits of ia*ib.
  - 1 MULH: high 64 bits, signed×signed.
  - 2 MULHSU: high 64 bits, signed ia × unsigned ib.
  - 3 MULHU: high 64 bits, unsigned×unsigned.
  - 4 DIV: signed quotient, truncated toward zero.
  - 5 DIVU: unsigned quotient.
  - 6 REM: signed remainder; sign follows the dividend.
  - 7 REMU: unsigned remainder.
  - 8 MULW: low 32 bits of ia[31:0]*ib[31:0].
  - 9 DIVW; 10 DIVUW; 11 REMW; 12 REMUW: same as 4–7 on the 32-bit operands ia[31:0], ib[31:0].
  - 13–15: reserved, output 0.
- Divide boundary cases, RISC-V semantics:
  - Divisor 0: DIV/DIVU quotient = all ones (-1). REM/REMU remainder = dividend (32-bit dividend for W forms, then sign-extended).
  - Signed overflow, dividend = most negative value and divisor = -1: quotient = dividend, remainder = 0. Applies to 64-bit and W forms (W overflow case is 0x80000000).
- Both outputs are computed regardless of which one the execute stage consumes. An unused unit's output is don't-care to the consumer but must still be the defined function above.
- No X may propagate on any encoded op.

Test Plan:
- ALU basics:
  - ADD: ia=0xFFFFFFFFFFFFFFFF, ib=1 → aluOut=0.
  - SUB: ia=0, ib=1 → aluOut=0xFFFFFFFFFFFFFFFF.
  - SLT: ia=-1, ib=1 → 1. SLTU with the same operands → 0.
- Shifts:
  - SRA: ia=0x8000000000000000, ib=63 → all ones.
  - SRL: same operands → 1.
  - SLL: ib=0x41 is masked to a shift of 1.
  - SRAW: ia=0x0000000080000000, ib=4 → 0xFFFFFFFFF8000000.
- Multiply:
  - MUL: ia=ib=0xFFFFFFFFFFFFFFFF → 1.
  - MULH: same operands → 0.
  - MULHU: same operands → 0xFFFFFFFFFFFFFFFE.
  - MULHSU: ia=-1, ib=2 → 0xFFFFFFFFFFFFFFFF.
  - MULW: ia=0x10000, ib=0x10000 → 0.
- Divide:
  - DIV: ia=-7, ib=2 → -3. REM: same operands → -1.
  - DIVU: ia=7, ib=2 → 3. REMU: same operands → 1.
- Divide edge cases:
  - DIV: ib=0 → -1. REM: ia=5, ib=0 → 5.
  - DIV: ia=0x8000000000000000, ib=-1 → 0x8000000000000000. REM with the same operands → 0.
  - DIVW: ia=0x80000000, ib=-1 → 0xFFFFFFFF80000000.
- Reset/combinational:
  - Hold rst high, change ia/ib → outputs track the inputs with no clock edge.
  - Reserved op codes → 0.
